// File: rtl/pulse_stretcher.sv
// -----------------------------------------------------------------------------
// pulse_stretcher
//   Turns single-cycle (or level) event requests into a stretched output pulse:
//   OutSignal is held high for HOLD_CYCLES cycles, then forced low for
//   GAP_CYCLES cycles before another event may start a new hold.
//
//   Optional feature (compile-time macro PULSE_STRETCHER_QUEUE_EN):
//     defined   - one event arriving during HOLD/GAP is remembered in a
//                 one-deep pending flag and replayed when GAP ends; further
//                 events while the flag is set are discarded.
//     undefined - every event arriving during HOLD/GAP is discarded.
//
// Ports
//   Clk       in   system clock, all state changes on rising edge
//   Rst       in   synchronous active-high reset, overrides every input
//   InPulse   in   event request, each high cycle is one event
//   OutSignal out  registered stretched pulse
//   Busy      out  registered, high while in HOLD or GAP
//   Dropped   out  registered, one-cycle pulse per discarded event
// -----------------------------------------------------------------------------
module pulse_stretcher #(
  parameter int unsigned HOLD_CYCLES = 32'd25000000,
  parameter int unsigned GAP_CYCLES  = 32'd12500000
) (
  input  logic Clk,
  input  logic Rst,
  input  logic InPulse,
  output logic OutSignal,
  output logic Busy,
  output logic Dropped
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // The counter holds "cycles remaining minus one", so zero marks the last
  // cycle of the current phase.
  localparam logic [31:0] HOLD_LOAD = 32'(HOLD_CYCLES - 32'd1);
  localparam logic [31:0] GAP_LOAD  = 32'(GAP_CYCLES - 32'd1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        drop_d;
  logic        out_q, busy_q, drop_q;
`ifdef PULSE_STRETCHER_QUEUE_EN
  logic        pend_q, pend_d;
`endif

  // Next-state, counter and discard decision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = 1'b0;
`ifdef PULSE_STRETCHER_QUEUE_EN
    pend_d  = pend_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (InPulse) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (cnt_q == 32'd0) begin
          state_d = S_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d   = cnt_q - 32'd1;
        end
        // Event while busy: remember one if possible, otherwise discard.
`ifdef PULSE_STRETCHER_QUEUE_EN
        if (InPulse && !pend_q) begin
          pend_d = 1'b1;
        end else begin
          drop_d = InPulse;
        end
`else
        drop_d = InPulse;
`endif
      end
      S_GAP: begin
        if (cnt_q == 32'd0) begin
          // Last GAP cycle: an event on this very edge is never discarded.
          // A pending event takes priority and the new one becomes pending.
`ifdef PULSE_STRETCHER_QUEUE_EN
          if (pend_q) begin
            state_d = S_HOLD;
            cnt_d   = HOLD_LOAD;
            pend_d  = InPulse;
          end else if (InPulse) begin
            state_d = S_HOLD;
            cnt_d   = HOLD_LOAD;
          end else begin
            state_d = S_IDLE;
            cnt_d   = 32'd0;
          end
`else
          if (InPulse) begin
            state_d = S_HOLD;
            cnt_d   = HOLD_LOAD;
          end else begin
            state_d = S_IDLE;
            cnt_d   = 32'd0;
          end
`endif
        end else begin
          cnt_d = cnt_q - 32'd1;
`ifdef PULSE_STRETCHER_QUEUE_EN
          if (InPulse && !pend_q) begin
            pend_d = 1'b1;
          end else begin
            drop_d = InPulse;
          end
`else
          drop_d = InPulse;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 32'd0;
      end
    endcase
  end

  // State, counter and output registers; outputs decoded from next state so
  // they are flops yet change on the same edge as the state.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 32'd0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
`ifdef PULSE_STRETCHER_QUEUE_EN
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= (state_d == S_HOLD);
      busy_q  <= (state_d != S_IDLE);
      drop_q  <= drop_d;
`ifdef PULSE_STRETCHER_QUEUE_EN
      pend_q  <= pend_d;
`endif
    end
  end

  assign OutSignal = out_q;
  assign Busy      = busy_q;
  assign Dropped   = drop_q;

endmodule
